// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: code table, frame length, receiver state encoding.
package seg_pkg;

  // Serial frame length: 7 segment bits (a..g, LSB first) plus one pad bit
  localparam int unsigned SEG_BITS = 8;

  // Segment codes, bit order {pad, g, f, e, d, c, b, a}
  localparam logic [SEG_BITS-1:0] SEG_0 = 8'h3F;
  localparam logic [SEG_BITS-1:0] SEG_1 = 8'h06;
  localparam logic [SEG_BITS-1:0] SEG_2 = 8'h5B;
  localparam logic [SEG_BITS-1:0] SEG_3 = 8'h4F;
  localparam logic [SEG_BITS-1:0] SEG_4 = 8'h66;
  localparam logic [SEG_BITS-1:0] SEG_5 = 8'h6D;
  localparam logic [SEG_BITS-1:0] SEG_6 = 8'h7D;
  localparam logic [SEG_BITS-1:0] SEG_7 = 8'h07;
  localparam logic [SEG_BITS-1:0] SEG_8 = 8'h7F;
  localparam logic [SEG_BITS-1:0] SEG_9 = 8'h6F;

  // Receiver frame state
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } rx_state_e;

  // Decoded digit: error flag plus BCD nibble (4'hF when err is set)
  typedef struct packed {
    logic       err;
    logic [3:0] nibble;
  } bcd_res_t;

endpackage

// File: rtl/seg2bcd.sv
// Combinational segment code to BCD decoder; anything outside the table is an error.
module seg2bcd
  import seg_pkg::*;
(
  input  logic [SEG_BITS-1:0] code_i,
  output bcd_res_t            res_o
);

  // Table lookup; pad bit set never matches, so it lands in the error default
  always_comb begin
    res_o = '{err: 1'b1, nibble: 4'hF};
    case (code_i)
      SEG_0:   res_o = '{err: 1'b0, nibble: 4'd0};
      SEG_1:   res_o = '{err: 1'b0, nibble: 4'd1};
      SEG_2:   res_o = '{err: 1'b0, nibble: 4'd2};
      SEG_3:   res_o = '{err: 1'b0, nibble: 4'd3};
      SEG_4:   res_o = '{err: 1'b0, nibble: 4'd4};
      SEG_5:   res_o = '{err: 1'b0, nibble: 4'd5};
      SEG_6:   res_o = '{err: 1'b0, nibble: 4'd6};
      SEG_7:   res_o = '{err: 1'b0, nibble: 4'd7};
      SEG_8:   res_o = '{err: 1'b0, nibble: 4'd8};
      SEG_9:   res_o = '{err: 1'b0, nibble: 4'd9};
      default: res_o = '{err: 1'b1, nibble: 4'hF};
    endcase
  end

endmodule

// File: rtl/segshift_receiver.sv
// Serial 7-segment link receiver: one bit per strobe edge on every lane, 8 edges per frame,
// each lane decoded back to BCD with a per-digit error flag. Partial frames time out.
module segshift_receiver
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS  = 6,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIGITS-1:0]     seg_in,
  input  logic                  shift_in,
  output logic [4*DIGITS-1:0]   cnt_out,
  output logic                  valid,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  timeout
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_W  = $clog2(SEG_BITS);
  localparam int unsigned SR_W   = SEG_BITS - 1;

  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(SEG_BITS - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

  rx_state_e             state_q;
  logic                  shift_prev_q;
  logic [CNT_W-1:0]      bitcnt_q;
  logic [IDLE_W-1:0]     idle_q;
  logic [SR_W-1:0]       sr_q [DIGITS];
  logic [4*DIGITS-1:0]   cnt_q;
  logic [DIGITS-1:0]     err_q;
  logic                  valid_q;
  logic                  timeout_q;

  logic                  edge_c;
  logic [IDLE_W-1:0]     idle_inc_c;
  bcd_res_t              dec_res_c [DIGITS];
  logic [4*DIGITS-1:0]   dec_cnt_c;
  logic [DIGITS-1:0]     dec_err_c;

  // Rising strobe edge and saturating idle-count increment
  assign edge_c     = shift_in & ~shift_prev_q;
  assign idle_inc_c = (idle_q == IDLE_MAX) ? idle_q : idle_q + IDLE_W'(1);

  // Per-lane decode of the frame completed by the current edge: {live bit, 7 stored bits}
  for (genvar d = 0; d < DIGITS; d++) begin : g_lane
    seg2bcd u_dec (
      .code_i ({seg_in[d], sr_q[d]}),
      .res_o  (dec_res_c[d])
    );
    assign dec_cnt_c[4*d +: 4] = dec_res_c[d].nibble;
    assign dec_err_c[d]        = dec_res_c[d].err;
  end

  // Frame FSM, bit/idle counters, lane shift registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      shift_prev_q <= 1'b1;
      bitcnt_q     <= '0;
      idle_q       <= '0;
      cnt_q        <= '0;
      err_q        <= '0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
      for (int d = 0; d < DIGITS; d++) sr_q[d] <= '0;
    end else begin
      shift_prev_q <= shift_in;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (edge_c) begin
            for (int d = 0; d < DIGITS; d++) sr_q[d][0] <= seg_in[d];
            bitcnt_q <= CNT_W'(1);
            idle_q   <= '0;
            state_q  <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (edge_c) begin
            idle_q <= '0;
            if (bitcnt_q == LAST_BIT) begin
              cnt_q    <= dec_cnt_c;
              err_q    <= dec_err_c;
              valid_q  <= 1'b1;
              bitcnt_q <= '0;
              state_q  <= ST_IDLE;
            end else begin
              for (int d = 0; d < DIGITS; d++) sr_q[d][bitcnt_q] <= seg_in[d];
              bitcnt_q <= bitcnt_q + CNT_W'(1);
            end
          end else if (idle_inc_c == IDLE_MAX) begin
            timeout_q <= 1'b1;
            idle_q    <= '0;
            bitcnt_q  <= '0;
            state_q   <= ST_IDLE;
          end else begin
            idle_q <= idle_inc_c;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cnt_out   = cnt_q;
  assign digit_err = err_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_segshift_receiver.sv
// Bench for segshift_receiver: table of known frames, hand-written multi-cycle corner
// cases, and random frames checked against a table-lookup reference decoder.
module tb_segshift_receiver;

  localparam int unsigned DIGITS  = 6;
  localparam int unsigned TIMEOUT = 32;

  logic                clk = 1'b0;
  logic                reset;
  logic [DIGITS-1:0]   seg_in;
  logic                shift_in;
  logic [4*DIGITS-1:0] cnt_out;
  logic                valid;
  logic [DIGITS-1:0]   digit_err;
  logic                timeout;

  int total = 0;
  int bad   = 0;
  int n_valid = 0;
  int n_tmo   = 0;

  logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                               8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  typedef struct {
    logic [47:0] codes;
    logic [23:0] cnt;
    logic [5:0]  err;
  } vec_t;

  vec_t vt [7];

  always #5 clk = ~clk;

  segshift_receiver #(.DIGITS(DIGITS), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .seg_in    (seg_in),
    .shift_in  (shift_in),
    .cnt_out   (cnt_out),
    .valid     (valid),
    .digit_err (digit_err),
    .timeout   (timeout)
  );

  // Pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (valid)   n_valid++;
    if (timeout) n_tmo++;
  end

  // Reference decode: search the legal table, anything else is an error
  function automatic logic [4:0] ref_dec(input logic [7:0] c);
    for (int i = 0; i < 10; i++)
      if (c == seg_tab[i]) return {1'b0, 4'(i)};
    return 5'h1F;
  endfunction

  function automatic logic [29:0] ref_frame(input logic [47:0] codes);
    logic [23:0] cnt;
    logic [5:0]  err;
    logic [4:0]  r;
    for (int d = 0; d < 6; d++) begin
      r = ref_dec(codes[d*8 +: 8]);
      cnt[d*4 +: 4] = r[3:0];
      err[d]        = r[4];
    end
    return {err, cnt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_cnt"},   32'(cnt_out),   32'h0);
    chk({nm, "_err"},   32'(digit_err), 32'h0);
    chk({nm, "_valid"}, 32'(valid),     32'h0);
    chk({nm, "_tmo"},   32'(timeout),   32'h0);
  endtask

  // Full frame: each edge held 'hold' cycles high, then 'gap' cycles low (gap >= 1)
  task automatic send_frame(input logic [47:0] codes, input logic [23:0] exp_cnt,
                            input logic [5:0] exp_err, input int hold, input int gap,
                            input string nm);
    int v0, t0;
    v0 = n_valid;
    t0 = n_tmo;
    for (int k = 0; k < 8; k++) begin
      for (int d = 0; d < 6; d++) seg_in[d] = codes[d*8 + k];
      shift_in = 1'b1;
      tick();
      if (k == 7) begin
        chk({nm, "_valid"}, 32'(valid),     32'h1);
        chk({nm, "_cnt"},   32'(cnt_out),   32'(exp_cnt));
        chk({nm, "_err"},   32'(digit_err), 32'(exp_err));
      end else begin
        chk({nm, "_early_valid"}, 32'(n_valid - v0), 32'h0);
      end
      for (int c = 0; c < hold - 1 + gap; c++) begin
        shift_in = (c < hold - 1);
        seg_in   = DIGITS'($urandom);
        tick();
        if (k == 7 && c == 0) begin
          chk({nm, "_valid_1cyc"}, 32'(valid),         32'h0);
          chk({nm, "_valid_cnt"},  32'(n_valid - v0),  32'h1);
        end
      end
    end
    chk({nm, "_no_tmo"}, 32'(n_tmo - t0), 32'h0);
  endtask

  // n edges of a frame, each one cycle high then one cycle low
  task automatic send_edges(input logic [47:0] codes, input int n);
    for (int k = 0; k < n; k++) begin
      for (int d = 0; d < 6; d++) seg_in[d] = codes[d*8 + k];
      shift_in = 1'b1;
      tick();
      shift_in = 1'b0;
      seg_in   = DIGITS'($urandom);
      tick();
    end
  endtask

  initial begin
    int v0, t0;
    logic [47:0] codes;
    logic [29:0] r;

    vt[0] = '{48'h065B4F666D7D, 24'h123456, 6'b000000};
    vt[1] = '{48'h065B4F496D7D, 24'h123F56, 6'b000100};
    vt[2] = '{48'h065B4F666DBF, 24'h12345F, 6'b000001};
    vt[3] = '{48'h3F3F3F3F3F3F, 24'h000000, 6'b000000};
    vt[4] = '{48'h6F6F6F6F6F6F, 24'h999999, 6'b000000};
    vt[5] = '{48'h666D077F6F3F, 24'h457890, 6'b000000};
    vt[6] = '{48'h00FF80863E7E, 24'hFFFFFF, 6'b111111};

    // Reset state
    reset    = 1'b1;
    shift_in = 1'b0;
    seg_in   = '0;
    tick();
    tick();
    chk_idle_outputs("reset");
    reset = 1'b0;
    tick();

    // Known frames, strobe alternating with varied hold/gap
    for (int i = 0; i < 7; i++)
      send_frame(vt[i].codes, vt[i].cnt, vt[i].err, 1 + (i % 2), 1 + (i % 3),
                 $sformatf("vec%0d", i));

    // Partial frame timeout: 32 no-edge cycles after the 4th edge
    v0 = n_valid;
    t0 = n_tmo;
    send_edges(vt[0].codes, 4);
    repeat (30) tick();
    chk("tmo_not_yet", 32'(timeout), 32'h0);
    chk("tmo_not_yet_cnt", 32'(n_tmo - t0), 32'h0);
    tick();
    chk("tmo_pulse", 32'(timeout), 32'h1);
    tick();
    chk("tmo_1cyc", 32'(timeout), 32'h0);
    chk("tmo_count", 32'(n_tmo - t0), 32'h1);
    chk("tmo_no_valid", 32'(n_valid - v0), 32'h0);
    chk("tmo_cnt_kept", 32'(cnt_out), 32'(vt[6].cnt));
    chk("tmo_err_kept", 32'(digit_err), 32'(vt[6].err));
    send_frame(vt[0].codes, vt[0].cnt, vt[0].err, 1, 1, "after_tmo");

    // Longest legal gap: 31 no-edge cycles between edges keeps the frame alive
    send_frame(vt[5].codes, vt[5].cnt, vt[5].err, 1, 31, "gap31");
    send_frame(vt[4].codes, vt[4].cnt, vt[4].err, 5, 27, "hold5gap27");

    // Strobe high through reset and 5 cycles after release: no edge
    v0 = n_valid;
    reset    = 1'b1;
    shift_in = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    repeat (5) begin
      seg_in = DIGITS'($urandom);
      tick();
    end
    shift_in = 1'b0;
    tick();
    chk("hi_reset_no_valid", 32'(n_valid - v0), 32'h0);
    send_frame(vt[5].codes, vt[5].cnt, vt[5].err, 1, 1, "after_hi_reset");

    // Reset mid-frame after 5 edges, then back-to-back frames
    v0 = n_valid;
    send_edges(vt[0].codes, 5);
    reset = 1'b1;
    tick();
    chk_idle_outputs("mid_reset");
    reset = 1'b0;
    tick();
    chk("mid_reset_no_valid", 32'(n_valid - v0), 32'h0);
    send_frame(vt[3].codes, vt[3].cnt, vt[3].err, 1, 1, "b2b_0");
    send_frame(vt[4].codes, vt[4].cnt, vt[4].err, 1, 1, "b2b_9");

    // Random frames against the reference decoder
    for (int i = 0; i < 40; i++) begin
      for (int d = 0; d < 6; d++) begin
        if ($urandom_range(0, 9) < 8) codes[d*8 +: 8] = seg_tab[$urandom_range(0, 9)];
        else                          codes[d*8 +: 8] = 8'($urandom);
      end
      r = ref_frame(codes);
      send_frame(codes, r[23:0], r[29:24], int'($urandom_range(1, 3)),
                 int'($urandom_range(1, 6)), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
